bf2_twiddle_stage: RTL
======================

BF2_TWIDDLE_STAGE -- requirements
Module: bf2_twiddle_stage

Interface
REQ-001 SHALL have parameter bit_width, default 29: width of each input real/imaginary sample.
REQ-002 SHALL have parameter N, default 16: FFT frame length; N/2 butterfly pairs per frame.
REQ-003 SHALL have parameter SIZE, default 4: log2(N).
REQ-004 SHALL have parameter TW_WIDTH, default 16: signed twiddle width, Q2.14 format (FRAC=14, so 1.0 = 16384).
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 en_add  in  1  one-cycle strobe marking a valid pair on the four sample inputs.
REQ-008 Re_i1, Im_i1  in  bit_width signed  first butterfly operand x1.
REQ-009 Re_i2, Im_i2  in  bit_width signed  second butterfly operand x2.
REQ-010 Re_o, Im_o  out  bit_width+1 signed  serialized butterfly result.
REQ-011 valid_o  out  1  high for each cycle Re_o/Im_o carries a result.
REQ-012 frame_done  out  1  one-cycle pulse coinciding with the last product of a frame.
REQ-013 err_o  out  1  sticky protocol-violation flag.

Function
REQ-014 Each accepted pair SHALL produce sum S = x1+x2 and product P = (x1-x2)*W[k], with W[k] = exp(-j*2*pi*k/N).
REQ-015 Pair index k SHALL come from a (SIZE-1)-bit counter: it increments per accepted pair, runs 0..N/2-1, and wraps to 0.
REQ-016 Stage 1 (edge after en_add sampled high) SHALL register S and D = x1-x2, sign-extended to bit_width+1 bits, together with a valid bit and k.
REQ-017 Stage 2 SHALL compute Re = Dr*Wr - Di*Wi and Im = Dr*Wi + Di*Wr at full precision, add 2^13, shift arithmetically right by 14, then saturate to [-2^bit_width, 2^bit_width-1]; S SHALL be delayed one cycle alongside.
REQ-018 S SHALL never overflow bit_width+1 bits; no saturation logic SHALL be applied to S.
REQ-019 Output serializer: if en_add is sampled in cycle T, S SHALL appear on Re_o/Im_o with valid_o=1 in cycle T+3 and P in cycle T+4.
REQ-020 When valid_o=0, Re_o/Im_o SHALL hold their last driven values.
REQ-021 Minimum en_add spacing SHALL be 2 cycles; full throughput is one pair per 2 cycles, which keeps valid_o continuously high.
REQ-022 An en_add high in the cycle directly after an accepted en_add SHALL be ignored (pair dropped, k not advanced) and SHALL set err_o to 1 until reset.
REQ-023 frame_done SHALL be 1 in exactly the cycle P of pair k=N/2-1 is output, and 0 otherwise.
REQ-024 The twiddle lookup SHALL be a registered read addressed by k on the accepting cycle, aligned with the stage-1 registers.
REQ-025 There SHALL be no backpressure; the downstream stage accepts every valid_o cycle.

Reset
REQ-026 With rst_n=0 at a clock edge: Re_o=0, Im_o=0, valid_o=0, frame_done=0, err_o=0, k=0, all pipeline valid bits cleared.
REQ-027 Reset asserted mid-operation SHALL discard in-flight pairs with no partial output afterwards; the first pair after reset SHALL use k=0.
REQ-028 en_add sampled while rst_n=0 SHALL be ignored.

Structure
REQ-029 Shared package fft_pkg SHALL hold FRAC=14, TW_WIDTH, and the rounding constant 2^13.
REQ-030 Sub-module tw_rom SHALL provide N/2 entries of {cos, -sin} in Q2.14 with a registered read; entry 0 = (16384,0) and entry N/4 = (0,-16384).
REQ-031 Datapath and serializer SHALL stay in bf2_twiddle_stage; the complex multiply SHALL be a 4-multiplier form (no 3-multiplier trick).

Verification
REQ-032 Reset: hold rst_n=0 for 2 cycles with en_add toggling -> all outputs 0, valid_o never 1.
REQ-033 k=0: x1=(100,50), x2=(40,-10) at cycle T -> (140,40) at T+3, (60,60) at T+4.
REQ-034 k=4 (W=-j): 4 dummy pairs, then x1=(100,50), x2=(40,-10) -> P=(60,-60).
REQ-035 Saturation at k=2 (W=(11585,-11585)): x1=(2^28-1,-2^28), x2=(-2^28,2^28-1) -> P=(0,-536870912).
REQ-036 en_add high in cycles T and T+1 -> only the T pair output, err_o=1 from T+2 until reset.
REQ-037 9 pairs spaced 2 cycles apart -> valid_o continuous, frame_done with the 8th P, 9th pair uses k=0.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants for the radix-2 FFT stages: Q2.14 twiddle format and rounding.
package fft_pkg;
   localparam int  FRAC     = 14;
   localparam int  TW_WIDTH = 16;
   localparam int  RND      = 1 << (FRAC - 1);
   localparam real PI       = 3.14159265358979323846;

   // Round a real value in [-2,2) to its nearest Q2.FRAC integer code (ties away from zero).
   function automatic int to_q(input real x);
      real s;
      s = x * real'(1 << FRAC);
      if (s >= 0.0) return $rtoi(s + 0.5);
      else          return -$rtoi(-s + 0.5);
   endfunction
endpackage

// File: rtl/tw_rom.sv
// Twiddle table W[k] = cos(2*pi*k/N) - j*sin(2*pi*k/N), k = 0..N/2-1, registered read.
module tw_rom #(
   parameter int N        = 16,
   parameter int SIZE     = 4,
   parameter int TW_WIDTH = 16
) (
   input  logic                       clk,
   input  logic [SIZE-2:0]            addr,
   output logic signed [TW_WIDTH-1:0] w_re,
   output logic signed [TW_WIDTH-1:0] w_im
);
   import fft_pkg::*;

   logic signed [TW_WIDTH-1:0] cos_tab  [N/2];
   logic signed [TW_WIDTH-1:0] nsin_tab [N/2];
   logic signed [TW_WIDTH-1:0] w_re_d, w_re_q, w_im_d, w_im_q;

   // Constant table contents, evaluated at elaboration
   for (genvar i = 0; i < N/2; i++) begin : g_tab
      assign cos_tab[i]  = TW_WIDTH'(to_q($cos(2.0 * PI * real'(i) / real'(N))));
      assign nsin_tab[i] = TW_WIDTH'(-to_q($sin(2.0 * PI * real'(i) / real'(N))));
   end

   // Combinational table lookup feeding the read register
   always_comb begin
      w_re_d = cos_tab[addr];
      w_im_d = nsin_tab[addr];
   end

   // Read register: output is valid the cycle after addr is presented
   always_ff @(posedge clk) begin
      w_re_q <= w_re_d;
      w_im_q <= w_im_d;
   end

   assign w_re = w_re_q;
   assign w_im = w_im_q;
endmodule

// File: rtl/bf2_twiddle_stage.sv
// Radix-2 DIF butterfly with twiddle multiply; S and P of each pair serialized on one port.
module bf2_twiddle_stage #(
   parameter int bit_width = 29,
   parameter int N         = 16,
   parameter int SIZE      = 4,
   parameter int TW_WIDTH  = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       en_add,
   input  logic signed [bit_width-1:0] Re_i1,
   input  logic signed [bit_width-1:0] Im_i1,
   input  logic signed [bit_width-1:0] Re_i2,
   input  logic signed [bit_width-1:0] Im_i2,
   output logic signed [bit_width:0]   Re_o,
   output logic signed [bit_width:0]   Im_o,
   output logic                       valid_o,
   output logic                       frame_done,
   output logic                       err_o
);
   import fft_pkg::*;

   localparam int OW = bit_width + 1;
   localparam int PW = OW + TW_WIDTH + 1;
   localparam int KW = SIZE - 1;
   localparam logic [KW-1:0]        K_LAST = KW'(N/2 - 1);
   localparam logic signed [PW-1:0] P_MAX  = (PW'(1) <<< bit_width) - PW'(1);
   localparam logic signed [PW-1:0] P_MIN  = -(PW'(1) <<< bit_width);

   function automatic logic signed [OW-1:0] sat(input logic signed [PW-1:0] v);
      if (v > P_MAX)      return P_MAX[OW-1:0];
      else if (v < P_MIN) return P_MIN[OW-1:0];
      else                return v[OW-1:0];
   endfunction

   logic                       accept;
   logic                       acc_d, acc_q, err_d, err_q;
   logic [KW-1:0]              k_d, k_q, k1_d, k1_q, k2_d, k2_q;
   logic [2:0]                 vld_pipe_d, vld_pipe_q;   // [0] stage1, [1] stage2, [2] P pending
   logic signed [OW-1:0]       s1_re_d, s1_re_q, s1_im_d, s1_im_q;
   logic signed [OW-1:0]       d1_re_d, d1_re_q, d1_im_d, d1_im_q;
   logic signed [OW-1:0]       s2_re_d, s2_re_q, s2_im_d, s2_im_q;
   logic signed [OW-1:0]       p2_re_d, p2_re_q, p2_im_d, p2_im_q;
   logic signed [OW-1:0]       re_o_d, re_o_q, im_o_d, im_o_q;
   logic                       valid_d, valid_q, fd_d, fd_q;
   logic signed [TW_WIDTH-1:0] tw_re, tw_im;
   logic signed [PW-1:0]       prod_re, prod_im, rnd_re, rnd_im;

   // Twiddle read addressed by k on the accepting cycle, lands alongside stage 1
   tw_rom #(.N(N), .SIZE(SIZE), .TW_WIDTH(TW_WIDTH)) u_tw_rom (
      .clk  (clk),
      .addr (k_q),
      .w_re (tw_re),
      .w_im (tw_im)
   );

   // Pair acceptance, k counter, sticky error and the valid shift register
   always_comb begin
      accept     = en_add & ~acc_q;
      acc_d      = accept;
      k_d        = accept ? ((k_q == K_LAST) ? '0 : k_q + 1'b1) : k_q;
      err_d      = err_q | (en_add & acc_q);
      vld_pipe_d = {vld_pipe_q[1:0], accept};
   end

   // Stage 1: sum and difference of the accepted pair
   always_comb begin
      s1_re_d = s1_re_q;
      s1_im_d = s1_im_q;
      d1_re_d = d1_re_q;
      d1_im_d = d1_im_q;
      k1_d    = k1_q;
      if (accept) begin
         s1_re_d = OW'(Re_i1) + OW'(Re_i2);
         s1_im_d = OW'(Im_i1) + OW'(Im_i2);
         d1_re_d = OW'(Re_i1) - OW'(Re_i2);
         d1_im_d = OW'(Im_i1) - OW'(Im_i2);
         k1_d    = k_q;
      end
   end

   // Stage 2: full-precision 4-multiplier complex product, round, shift, saturate
   always_comb begin
      prod_re = PW'(d1_re_q) * PW'(tw_re) - PW'(d1_im_q) * PW'(tw_im);
      prod_im = PW'(d1_re_q) * PW'(tw_im) + PW'(d1_im_q) * PW'(tw_re);
      rnd_re  = (prod_re + PW'(RND)) >>> FRAC;
      rnd_im  = (prod_im + PW'(RND)) >>> FRAC;
      s2_re_d = s2_re_q;
      s2_im_d = s2_im_q;
      p2_re_d = p2_re_q;
      p2_im_d = p2_im_q;
      k2_d    = k2_q;
      // Stage 2 holds until the next pair so P is still here for the serializer
      if (vld_pipe_q[0]) begin
         s2_re_d = s1_re_q;
         s2_im_d = s1_im_q;
         p2_re_d = sat(rnd_re);
         p2_im_d = sat(rnd_im);
         k2_d    = k1_q;
      end
   end

   // Serializer: S one cycle, P the next; outputs hold when idle
   always_comb begin
      re_o_d  = re_o_q;
      im_o_d  = im_o_q;
      valid_d = 1'b0;
      fd_d    = 1'b0;
      if (vld_pipe_q[1]) begin
         re_o_d  = s2_re_q;
         im_o_d  = s2_im_q;
         valid_d = 1'b1;
      end else if (vld_pipe_q[2]) begin
         re_o_d  = p2_re_q;
         im_o_d  = p2_im_q;
         valid_d = 1'b1;
         fd_d    = (k2_q == K_LAST);
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q <= 1'b0;  err_q <= 1'b0;  k_q <= '0;  k1_q <= '0;  k2_q <= '0;
         vld_pipe_q <= '0;
         s1_re_q <= '0;  s1_im_q <= '0;  d1_re_q <= '0;  d1_im_q <= '0;
         s2_re_q <= '0;  s2_im_q <= '0;  p2_re_q <= '0;  p2_im_q <= '0;
         re_o_q <= '0;  im_o_q <= '0;  valid_q <= 1'b0;  fd_q <= 1'b0;
      end else begin
         acc_q <= acc_d;  err_q <= err_d;  k_q <= k_d;  k1_q <= k1_d;  k2_q <= k2_d;
         vld_pipe_q <= vld_pipe_d;
         s1_re_q <= s1_re_d;  s1_im_q <= s1_im_d;  d1_re_q <= d1_re_d;  d1_im_q <= d1_im_d;
         s2_re_q <= s2_re_d;  s2_im_q <= s2_im_d;  p2_re_q <= p2_re_d;  p2_im_q <= p2_im_d;
         re_o_q <= re_o_d;  im_o_q <= im_o_d;  valid_q <= valid_d;  fd_q <= fd_d;
      end
   end

   assign Re_o       = re_o_q;
   assign Im_o       = im_o_q;
   assign valid_o    = valid_q;
   assign frame_done = fd_q;
   assign err_o      = err_q;
endmodule
